// File: rtl/delay_mem_arb.sv
// Two-requester arbiter in front of a single-port delay RAM. Each requester
// may be granted at most BUDGET times per sample frame; ties are round-robin.
module delay_mem_arb #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int BUDGET = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              VALID,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic              overrun0,
   output logic              overrun1,
   input  logic              clr_overrun,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [3:0] BUDGET_C = 4'(BUDGET);

   logic       valid_r;
   logic [3:0] cnt0_r;
   logic [3:0] cnt1_r;
   logic       last_gnt_r;
   logic       rvalid0_r;
   logic       rvalid1_r;
   logic       overrun0_r;
   logic       overrun1_r;

   logic       frame_start_s;
   logic       elig0_s;
   logic       elig1_s;
   logic       gnt0_s;
   logic       gnt1_s;

   // A frame start refreshes the budget, so the counter limit is bypassed on that cycle.
   always_comb begin
      frame_start_s = VALID & ~valid_r;
      elig0_s       = req0 & (frame_start_s | (cnt0_r < BUDGET_C));
      elig1_s       = req1 & (frame_start_s | (cnt1_r < BUDGET_C));
      gnt0_s        = 1'b0;
      gnt1_s        = 1'b0;
      if (rst_n) begin
         case ({elig1_s, elig0_s})
            2'b01:   gnt0_s = 1'b1;
            2'b10:   gnt1_s = 1'b1;
            2'b11: begin
               if (last_gnt_r) begin
                  gnt0_s = 1'b1;
               end else begin
                  gnt1_s = 1'b1;
               end
            end
            default: begin
               gnt0_s = 1'b0;
               gnt1_s = 1'b0;
            end
         endcase
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   always_comb begin
      mem_en    = gnt0_s | gnt1_s;
      mem_we    = 1'b0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
      if (gnt1_s) begin
         mem_we    = we1;
         mem_addr  = addr1;
         mem_wdata = wdata1;
      end else if (gnt0_s) begin
         mem_we    = we0;
         mem_addr  = addr0;
         mem_wdata = wdata0;
      end else begin
         mem_we    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_r    <= 1'b0;
         cnt0_r     <= 4'd0;
         cnt1_r     <= 4'd0;
         last_gnt_r <= 1'b1;
         rvalid0_r  <= 1'b0;
         rvalid1_r  <= 1'b0;
         overrun0_r <= 1'b0;
         overrun1_r <= 1'b0;
      end else begin
         valid_r   <= VALID;
         rvalid0_r <= gnt0_s & ~we0;
         rvalid1_r <= gnt1_s & ~we1;

         if (gnt1_s) begin
            last_gnt_r <= 1'b1;
         end else if (gnt0_s) begin
            last_gnt_r <= 1'b0;
         end else begin
            last_gnt_r <= last_gnt_r;
         end

         // Grants only happen below the budget, so the increment never passes BUDGET.
         if (frame_start_s) begin
            cnt0_r <= {3'd0, gnt0_s};
            cnt1_r <= {3'd0, gnt1_s};
         end else begin
            cnt0_r <= cnt0_r + {3'd0, gnt0_s};
            cnt1_r <= cnt1_r + {3'd0, gnt1_s};
         end

         if (frame_start_s & req0 & (cnt0_r == BUDGET_C)) begin
            overrun0_r <= 1'b1;
         end else if (clr_overrun) begin
            overrun0_r <= 1'b0;
         end else begin
            overrun0_r <= overrun0_r;
         end

         if (frame_start_s & req1 & (cnt1_r == BUDGET_C)) begin
            overrun1_r <= 1'b1;
         end else if (clr_overrun) begin
            overrun1_r <= 1'b0;
         end else begin
            overrun1_r <= overrun1_r;
         end
      end
   end

   assign gnt0     = gnt0_s;
   assign gnt1     = gnt1_s;
   assign rdata    = mem_rdata;
   assign rvalid0  = rvalid0_r;
   assign rvalid1  = rvalid1_r;
   assign overrun0 = overrun0_r;
   assign overrun1 = overrun1_r;

endmodule

// File: tb/tb_delay_mem_arb.sv
// Bench for delay_mem_arb: directed scenarios then random traffic, all checked
// cycle by cycle against a per-frame budget / round-robin reference model.
module tb_delay_mem_arb;

   localparam int BUDGET = 4;

   logic        clk = 1'b0;
   logic        rst_n, VALID, req0, req1, we0, we1, clr_overrun;
   logic [8:0]  addr0, addr1, mem_addr;
   logic [15:0] wdata0, wdata1, rdata, mem_wdata;
   logic [15:0] mem_rdata = 16'd0;
   logic        gnt0, gnt1, rvalid0, rvalid1, overrun0, overrun1, mem_en, mem_we;

   logic [15:0] ram [0:511];
   logic [15:0] ref_mem [0:511];
   bit          ram_ready = 1'b0;

   bit          m_valid_prev;
   int          m_cnt [2];
   int          m_last;
   bit          m_rv [2];
   bit          m_ov [2];
   logic [15:0] m_rdata;
   int          last_w;
   int          g0, g1;
   int          n_checks = 0;
   int          n_fail = 0;

   delay_mem_arb #(.ADDR_W(9), .DATA_W(16), .BUDGET(BUDGET)) dut (
      .clk(clk), .rst_n(rst_n), .VALID(VALID),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .overrun0(overrun0), .overrun1(overrun1), .clr_overrun(clr_overrun),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM with one-cycle read latency.
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 512; i++) ram[i] <= 16'(i * 3 + 7);
         ram_ready <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: predict, compare at mid-cycle, then advance the model at the edge.
   task automatic run_cycle();
      bit fs, el0, el1;
      int w;
      #4;
      fs  = VALID && !m_valid_prev;
      el0 = req0 && (fs || m_cnt[0] < BUDGET);
      el1 = req1 && (fs || m_cnt[1] < BUDGET);
      if (!rst_n)          w = -1;
      else if (el0 && el1) w = (m_last == 1) ? 0 : 1;
      else if (el0)        w = 0;
      else if (el1)        w = 1;
      else                 w = -1;

      check_val("gnt0", gnt0, w == 0);
      check_val("gnt1", gnt1, w == 1);
      check_val("mem_en", mem_en, w >= 0);
      if (w == 0) begin
         check_val("mem_we", mem_we, we0);
         check_val("mem_addr", mem_addr, addr0);
         if (we0) check_val("mem_wdata", mem_wdata, wdata0);
      end else if (w == 1) begin
         check_val("mem_we", mem_we, we1);
         check_val("mem_addr", mem_addr, addr1);
         if (we1) check_val("mem_wdata", mem_wdata, wdata1);
      end else begin
         check_val("mem_we_idle", mem_we, 1'b0);
      end
      check_val("rvalid0", rvalid0, m_rv[0]);
      check_val("rvalid1", rvalid1, m_rv[1]);
      check_val("overrun0", overrun0, m_ov[0]);
      check_val("overrun1", overrun1, m_ov[1]);
      if (m_rv[0] || m_rv[1]) check_val("rdata", rdata, m_rdata);
      if (gnt0 === 1'b1) g0++;
      if (gnt1 === 1'b1) g1++;
      last_w = w;

      @(posedge clk);
      if (!rst_n) begin
         m_valid_prev = 1'b0;
         m_cnt[0] = 0;  m_cnt[1] = 0;
         m_last = 1;
         m_rv[0] = 1'b0; m_rv[1] = 1'b0;
         m_ov[0] = 1'b0; m_ov[1] = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit rq, wr;
            rq = (i == 0) ? req0 : req1;
            wr = (i == 0) ? we0 : we1;
            if (fs && rq && m_cnt[i] == BUDGET) m_ov[i] = 1'b1;
            else if (clr_overrun)                m_ov[i] = 1'b0;
            m_cnt[i] = fs ? int'(w == i) : m_cnt[i] + int'(w == i);
            m_rv[i]  = (w == i) && !wr;
         end
         if (w == 0) begin
            if (we0) ref_mem[addr0] = wdata0;
            else     m_rdata = ref_mem[addr0];
         end else if (w == 1) begin
            if (we1) ref_mem[addr1] = wdata1;
            else     m_rdata = ref_mem[addr1];
         end
         if (w >= 0) m_last = w;
         m_valid_prev = VALID;
      end
      #1;
   endtask

   task automatic run_n(input int n);
      for (int k = 0; k < n; k++) run_cycle();
   endtask

   initial begin
      for (int i = 0; i < 512; i++) ref_mem[i] = 16'(i * 3 + 7);
      m_valid_prev = 1'b0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      m_last = 1;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      m_ov[0] = 1'b0; m_ov[1] = 1'b0;
      m_rdata = 16'd0;
      last_w = -1;
      rst_n = 1'b0; VALID = 1'b0; clr_overrun = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 9'd0; addr1 = 9'd0; wdata0 = 16'd0; wdata1 = 16'd0;
      @(posedge clk);
      #1;
      run_n(2);
      rst_n = 1'b1;

      // Both reading from reset: alternate until each budget is spent.
      req0 = 1'b1; req1 = 1'b1; addr0 = 9'd3; addr1 = 9'd5;
      g0 = 0; g1 = 0;
      run_n(10);
      check_val("burst_g0", g0, 4);
      check_val("burst_g1", g1, 4);

      // Exhausted req1 still pending at the frame edge.
      req0 = 1'b0; VALID = 1'b1; g1 = 0;
      run_cycle();
      check_val("ovr1_set", overrun1, 1'b1);
      check_val("ovr0_quiet", overrun0, 1'b0);
      check_val("fs_gnt1", g1, 1);
      run_n(6);
      check_val("hold_valid_g1", g1, 4);
      check_val("ovr1_sticky", overrun1, 1'b1);
      clr_overrun = 1'b1;
      run_cycle();
      clr_overrun = 1'b0;
      check_val("ovr1_clr", overrun1, 1'b0);

      // Set beats clear on the same cycle.
      VALID = 1'b0;
      run_cycle();
      VALID = 1'b1; clr_overrun = 1'b1;
      run_cycle();
      clr_overrun = 1'b0;
      check_val("set_wins", overrun1, 1'b1);

      // Write then read back the top word.
      req1 = 1'b0; VALID = 1'b0;
      run_cycle();
      VALID = 1'b1; req0 = 1'b1; we0 = 1'b1; addr0 = 9'h1FF; wdata0 = 16'hA5A5;
      run_cycle();
      we0 = 1'b0;
      run_cycle();
      check_val("rb_rvalid0", rvalid0, 1'b1);
      check_val("rb_rdata", rdata, 16'hA5A5);
      req0 = 1'b0;

      // req1 alone for a frame, then a tie goes to requester 0.
      VALID = 1'b0;
      run_cycle();
      VALID = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 9'd2; g0 = 0; g1 = 0;
      run_n(6);
      check_val("solo_g1", g1, 4);
      check_val("solo_g0", g0, 0);
      VALID = 1'b0;
      run_cycle();
      VALID = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 9'd4; g0 = 0; g1 = 0;
      run_cycle();
      check_val("tie_g0", g0, 1);
      check_val("tie_g1", g1, 0);

      // Reset in the middle of a read burst.
      req1 = 1'b0;
      run_cycle();
      rst_n = 1'b0;
      run_cycle();
      check_val("rst_rvalid0", rvalid0, 1'b0);
      rst_n = 1'b1; g0 = 0;
      run_n(8);
      check_val("post_rst_g0", g0, 4);

      // Random traffic; requests are held until granted.
      for (int c = 0; c < 800; c++) begin
         if (!req0 || last_w == 0) begin
            req0   = ($urandom_range(0, 2) != 0);
            we0    = ($urandom_range(0, 2) == 0);
            addr0  = ($urandom_range(0, 4) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
            wdata0 = 16'($urandom);
         end
         if (!req1 || last_w == 1) begin
            req1   = ($urandom_range(0, 2) != 0);
            we1    = ($urandom_range(0, 2) == 0);
            addr1  = ($urandom_range(0, 4) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
            wdata1 = 16'($urandom);
         end
         if ($urandom_range(0, 5) == 0) VALID = ~VALID;
         rst_n       = ($urandom_range(0, 149) != 0);
         clr_overrun = ($urandom_range(0, 15) == 0);
         run_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/delay_mem_arb.md
DELAY_MEM_ARB -- requirements
Module: delay_mem_arb

Interface
REQ-001: Parameter ADDR_W, default 9, delay-RAM address width (512 words).
REQ-002: Parameter DATA_W, default 16, sample width.
REQ-003: Parameter BUDGET, default 4, maximum grants per requester per sample frame (range 1-15).
REQ-004: clk  in  1  system clock; all logic on rising edge.
REQ-005: rst_n  in  1  reset; synchronous, active-low.
REQ-006: VALID  in  1  sample strobe (level); rising edge starts a new sample frame.
REQ-007: req0/req1  in  1 each  access request from requester 0/1.
REQ-008: we0/we1  in  1 each  1 = write, 0 = read.
REQ-009: addr0/addr1  in  ADDR_W each  access address.
REQ-010: wdata0/wdata1  in  DATA_W each  write data.
REQ-011: gnt0/gnt1  out  1 each  combinational grant; the access is issued in the same cycle.
REQ-012: rdata  out  DATA_W  read data; equals mem_rdata, shared by both requesters.
REQ-013: rvalid0/rvalid1  out  1 each  rdata valid for requester 0/1.
REQ-014: overrun0/overrun1  out  1 each  sticky frame-budget overrun flag.
REQ-015: clr_overrun  in  1  clears both overrun flags.
REQ-016: mem_en, mem_we  out  1 each  single-port RAM enable and write strobe.
REQ-017: mem_addr/mem_wdata  out  ADDR_W/DATA_W  RAM address and write data.
REQ-018: mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read enable.

Function
REQ-019: Register VALID into valid_q; frame_start = VALID & ~valid_q, asserted for exactly one cycle per rising edge.
REQ-020: Per-requester grant counter cnt_i, 4 bits; eligible_i = req_i & (cnt_i < BUDGET), except that eligible_i = req_i on a frame_start cycle (new budget).
REQ-021: At most one grant per cycle; gnt_i is asserted only when eligible_i.
REQ-022: Only one requester eligible: grant it.
REQ-023: Both eligible: grant the requester not granted most recently (round-robin pointer last_gnt); last_gnt updates only on a grant.
REQ-024: Grant mux: mem_en = gnt0|gnt1; mem_we/mem_addr/mem_wdata are taken from the granted requester; with no grant, mem_en=0, mem_we=0 and addr/wdata are don't-care.
REQ-025: Requesters hold req/we/addr/wdata stable until gnt; the block does not register the request.
REQ-026: rvalid_i is asserted exactly one cycle after a cycle with gnt_i & ~we_i; a write grant never produces rvalid.
REQ-027: Counter update: frame_start sets cnt_i to gnt_i ? 1 : 0; otherwise gnt_i increments cnt_i; cnt_i never exceeds BUDGET.
REQ-028: overrun_i sets on frame_start when req_i=1 and cnt_i==BUDGET (request still pending at frame end with budget exhausted).
REQ-029: overrun_i clears on clr_overrun; set wins over clear in the same cycle.
REQ-030: A requester with exhausted budget stays ungranted until the next frame_start; the other requester may use every remaining cycle up to its own budget.
REQ-031: VALID held high produces no further frame_start; VALID low-to-high on consecutive cycles yields a frame_start each time.

Reset
REQ-032: On rising clk with rst_n=0, the following take their reset values: valid_q=0, cnt0=cnt1=0, last_gnt=1 (requester 0 wins the first tie), rvalid0=rvalid1=0, overrun0=overrun1=0.
REQ-033: gnt0, gnt1 and mem_en are forced to 0 while rst_n=0; a read granted the cycle before reset produces no rvalid after reset.

Verification
REQ-034: After reset, req0=req1=1 (both read) held -> grants alternate 0,1,0,1,... until each has 4 grants; then no grants; each rvalid follows its grant by one cycle.
REQ-035: req0 write addr 0x1FF data 0xA5A5, then req0 read 0x1FF -> mem_we=1 on the first grant; rdata=0xA5A5 with rvalid0=1 one cycle after the read grant.
REQ-036: req1 held through 4 grants then still requesting at the next VALID rise -> overrun1=1 and gnt1=1 on the frame_start cycle; overrun1 stays 1 until clr_overrun.
REQ-037: clr_overrun=1 on the same cycle as an overrun-setting frame_start -> overrun stays 1.
REQ-038: Only req1 active for a full frame -> 4 consecutive grants to req1, gnt0 stays 0; a later tie goes to requester 0.
REQ-039: rst_n=0 mid-burst (cnt0=2, read just granted) -> next cycle rvalid0=0 and cnt0=0; after release, requester 0 receives 4 grants in the frame.
